// File: rtl/pipe_credit_pkg.sv
// Shared sizing helpers and default parameters for the credit-gated pipeline drain.
package pipe_credit_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_LATENCY = 2;

    // Bits needed to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_drain_fifo.sv
// Result FIFO behind the pipeline: DEPTH x WIDTH storage, wrapping pointers, occupancy count
// and a sticky flag for results that arrive while the FIFO is full and not draining.
module pipe_drain_fifo
    import pipe_credit_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pipe_credit_drain.sv
// Ready/valid wrapper for a non-stallable fixed-latency pipeline: issues work only when a
// result slot is reserved, and buffers returning results for a ready/valid consumer.
module pipe_credit_drain
    import pipe_credit_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int LATENCY = DEF_LATENCY,
    localparam int CNT_W   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pipe_input_valid,
    input  logic             pipe_output_valid,
    input  logic [WIDTH-1:0] pipe_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] credits,
    output logic             overflow_err
);

    if (DEPTH < 1 || LATENCY < 1) begin : g_param_check
        $error("pipe_credit_drain: DEPTH and LATENCY must both be at least 1");
    end

    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   used;
    logic             fifo_empty;
    logic             issue;

    assign used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);

    // Saturate at zero so a stray pipeline result cannot wrap the credit count.
    always_comb begin
        // NOTE: credits gets a default before any condition, so no latch is inferred.
        credits = '0;
        if (used < DEPTH_W) credits = CNT_W'(DEPTH_W - used);
    end

    assign in_ready         = rst & (credits != '0);
    assign issue            = in_valid & in_ready;
    assign pipe_input_valid = issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else if (issue && !pipe_output_valid) begin
            inflight <= inflight + 1'b1;
        end else if (!issue && pipe_output_valid && inflight != '0) begin
            inflight <= inflight - 1'b1;
        end
    end

    pipe_drain_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_output_valid),
        .push_data (pipe_out),
        .pop       (out_ready),
        .head_data (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .overflow  (overflow_err)
    );

    assign out_valid = ~fifo_empty;

endmodule
